// File: rtl/idli_fetch_buf_m_if.sv
// Fetch-buffer handshake bundle.
// Carries the SQI nibble stream, counter phase and flush into the buffer, and the
// decoder-facing instruction handshake, stall and overflow flags back out.
//   master : upstream/decoder side (drives i_* signals, observes o_* signals)
//   slave  : the fetch buffer itself
interface idli_fetch_buf_m_if;
    logic [1:0]  i_fb_ctr;
    logic        i_fb_ctr_last_cycle;
    logic [3:0]  i_fb_rd_data;
    logic        i_fb_rd_data_vld;
    logic        i_fb_flush;
    logic [15:0] o_fb_instr;
    logic        o_fb_instr_vld;
    logic        i_fb_instr_acp;
    logic        o_fb_stall;
    logic        o_fb_ovf;

    modport master (
        output i_fb_ctr, i_fb_ctr_last_cycle, i_fb_rd_data, i_fb_rd_data_vld,
               i_fb_flush, i_fb_instr_acp,
        input  o_fb_instr, o_fb_instr_vld, o_fb_stall, o_fb_ovf
    );

    modport slave (
        input  i_fb_ctr, i_fb_ctr_last_cycle, i_fb_rd_data, i_fb_rd_data_vld,
               i_fb_flush, i_fb_instr_acp,
        output o_fb_instr, o_fb_instr_vld, o_fb_stall, o_fb_ovf
    );
endinterface

// File: rtl/idli_fetch_buf_m.sv
// Instruction fetch buffer.
// Assembles four little-endian nibbles (one per counter value) into a 16-bit word and
// pushes complete words into a DEPTH-entry first-word-fall-through FIFO read by the decoder.
// Ports:
//   i_fb_gck   : core clock, all state updates on posedge
//   i_fb_rst_n : synchronous active-low reset, overrides flush and handshakes
//   io_fb      : slave side of idli_fetch_buf_m_if
//                (nibble input, flush, instr/vld/acp handshake, stall, ovf)
module idli_fetch_buf_m #(
    parameter int unsigned DEPTH = 2  // 2 or 4
) (
    input  logic                i_fb_gck,
    input  logic                i_fb_rst_n,
    idli_fetch_buf_m_if.slave   io_fb
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    // Only the three earlier nibbles need storing; the top nibble arrives on the
    // completing cycle and goes straight into the FIFO.
    logic [11:0]   r_asm;
    logic [2:0]    r_mask;
    logic          r_ovf;

    logic          w_full;
    logic          w_vld;
    logic          w_complete;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [15:0]   w_word;

    assign w_full     = (r_count == FULL);
    assign w_vld      = (r_count != '0);
    assign w_complete = io_fb.i_fb_ctr_last_cycle & io_fb.i_fb_rd_data_vld & (&r_mask);
    assign w_pop      = w_vld & io_fb.i_fb_instr_acp;
    // A pop in the same cycle frees the slot, so pushing while full is legal then.
    assign w_push     = w_complete & (~w_full | w_pop);
    assign w_drop     = w_complete & w_full & ~w_pop;
    assign w_word     = {io_fb.i_fb_rd_data, r_asm};

    // Nibble assembly
    always_ff @(posedge i_fb_gck) begin
        if (!i_fb_rst_n) begin
            r_asm  <= '0;
            r_mask <= '0;
        end else if (io_fb.i_fb_flush || io_fb.i_fb_ctr_last_cycle) begin
            // Mask clears at every period end, after the push decision used it.
            r_mask <= '0;
        end else if (io_fb.i_fb_rd_data_vld) begin
            case (io_fb.i_fb_ctr)
                2'd0: begin r_asm[3:0]  <= io_fb.i_fb_rd_data; r_mask[0] <= 1'b1; end
                2'd1: begin r_asm[7:4]  <= io_fb.i_fb_rd_data; r_mask[1] <= 1'b1; end
                2'd2: begin r_asm[11:8] <= io_fb.i_fb_rd_data; r_mask[2] <= 1'b1; end
                default: ;
            endcase
        end
    end

    // FIFO control
    always_ff @(posedge i_fb_gck) begin
        if (!i_fb_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (io_fb.i_fb_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= w_drop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage, cleared at reset so the head reads 0 rather than X
    always_ff @(posedge i_fb_gck) begin
        if (!i_fb_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!io_fb.i_fb_flush && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign io_fb.o_fb_instr     = r_mem[r_rd_ptr];
    assign io_fb.o_fb_instr_vld = w_vld;
    assign io_fb.o_fb_stall     = w_full;
    assign io_fb.o_fb_ovf       = r_ovf;

endmodule

// File: tb/tb_idli_fetch_buf_m.sv
module tb_idli_fetch_buf_m;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] ct = 2'd0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of buffered words plus captured-nibble bookkeeping.
    logic [15:0] m_q[$];
    bit          m_have[3];
    logic [3:0]  m_nib[3];
    logic        m_ovf;

    idli_fetch_buf_m_if fb ();

    idli_fetch_buf_m #(.DEPTH(DEPTH)) dut (
        .i_fb_gck   (clk),
        .i_fb_rst_n (rst_n),
        .io_fb      (fb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < 3; i++) m_have[i] = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_update();
        bit          complete;
        logic [15:0] word;
        if (!rst_n || fb.i_fb_flush) begin
            model_clear();
        end else begin
            complete = fb.i_fb_ctr_last_cycle && fb.i_fb_rd_data_vld &&
                       m_have[0] && m_have[1] && m_have[2];
            word = {fb.i_fb_rd_data, m_nib[2], m_nib[1], m_nib[0]};
            m_ovf = 1'b0;
            if (m_q.size() != 0 && fb.i_fb_instr_acp) void'(m_q.pop_front());
            if (complete) begin
                if (m_q.size() < DEPTH) m_q.push_back(word);
                else m_ovf = 1'b1;
            end
            if (fb.i_fb_ctr_last_cycle) begin
                for (int i = 0; i < 3; i++) m_have[i] = 1'b0;
            end else if (fb.i_fb_rd_data_vld && ct != 2'd3) begin
                m_nib[ct]  = fb.i_fb_rd_data;
                m_have[ct] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("vld",   16'(fb.o_fb_instr_vld), 16'(m_q.size() != 0));
        chk("stall", 16'(fb.o_fb_stall),     16'(m_q.size() == DEPTH));
        chk("ovf",   16'(fb.o_fb_ovf),       16'(m_ovf));
        if (m_q.size() != 0) chk("instr", fb.o_fb_instr, m_q[0]);
    endtask

    // One clock: drive inputs, let the edge happen, update model, check at negedge.
    task automatic step(input logic v, input logic [3:0] d, input logic acp,
                        input logic fl, input logic rn);
        fb.i_fb_ctr            = ct;
        fb.i_fb_ctr_last_cycle = (ct == 2'd3);
        fb.i_fb_rd_data        = d;
        fb.i_fb_rd_data_vld    = v;
        fb.i_fb_instr_acp      = acp;
        fb.i_fb_flush          = fl;
        rst_n                  = rn;
        @(posedge clk);
        model_update();
        ct = ct + 2'd1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic align();
        while (ct != 2'd0) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic acp);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, acp, 1'b0, 1'b1);
    endtask

    task automatic do_flush();
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        align();
    endtask

    task automatic send_word(input logic [15:0] w, input logic [3:0] vmask,
                             input logic acp_last, input logic fl_last);
        align();
        for (int i = 0; i < 4; i++)
            step(vmask[i], w[i*4 +: 4], (i == 3) ? acp_last : 1'b0,
                 (i == 3) ? fl_last : 1'b0, 1'b1);
    endtask

    initial begin
        fb.i_fb_ctr = '0; fb.i_fb_ctr_last_cycle = 1'b0; fb.i_fb_rd_data = '0;
        fb.i_fb_rd_data_vld = 1'b0; fb.i_fb_instr_acp = 1'b0; fb.i_fb_flush = 1'b0;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) m_nib[i] = 4'h0;
        @(negedge clk);

        // Reset state
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_instr", fb.o_fb_instr, 16'h0000);

        // 1: basic assembly, held without accept
        send_word(16'h4321, 4'hF, 1'b0, 1'b0);
        chk("t1_instr", fb.o_fb_instr, 16'h4321);
        idle(3, 1'b0);
        chk("t1_hold", fb.o_fb_instr, 16'h4321);
        do_flush();

        // 2: fill, overflow, drain
        send_word(16'hA5A5, 4'hF, 1'b0, 1'b0);
        send_word(16'h1234, 4'hF, 1'b0, 1'b0);
        chk("t2_stall", 16'(fb.o_fb_stall), 16'd1);
        send_word(16'hFFFF, 4'hF, 1'b0, 1'b0);
        chk("t2_ovf", 16'(fb.o_fb_ovf), 16'd1);
        idle(1, 1'b0);
        chk("t2_ovf_end", 16'(fb.o_fb_ovf), 16'd0);
        chk("t2_head0", fb.o_fb_instr, 16'hA5A5);
        idle(1, 1'b1);
        chk("t2_head1", fb.o_fb_instr, 16'h1234);
        idle(1, 1'b1);
        chk("t2_empty", 16'(fb.o_fb_instr_vld), 16'd0);

        // 3: push while full with simultaneous accept
        send_word(16'hA5A5, 4'hF, 1'b0, 1'b0);
        send_word(16'h1234, 4'hF, 1'b0, 1'b0);
        send_word(16'hFFFF, 4'hF, 1'b1, 1'b0);
        chk("t3_ovf", 16'(fb.o_fb_ovf), 16'd0);
        chk("t3_stall", 16'(fb.o_fb_stall), 16'd1);
        chk("t3_head", fb.o_fb_instr, 16'h1234);
        idle(1, 1'b1);
        chk("t3_next", fb.o_fb_instr, 16'hFFFF);
        idle(1, 1'b1);

        // 4: missing nibble discards the word
        send_word(16'hDEAD, 4'b1101, 1'b0, 1'b0);
        chk("t4_nopush", 16'(fb.o_fb_instr_vld), 16'd0);
        send_word(16'hBEEF, 4'hF, 1'b0, 1'b0);
        chk("t4_beef", fb.o_fb_instr, 16'hBEEF);
        do_flush();

        // 5: flush beats push and accept
        send_word(16'h1111, 4'hF, 1'b0, 1'b0);
        send_word(16'h2222, 4'hF, 1'b0, 1'b0);
        send_word(16'h3333, 4'hF, 1'b1, 1'b1);
        chk("t5_vld", 16'(fb.o_fb_instr_vld), 16'd0);
        chk("t5_stall", 16'(fb.o_fb_stall), 16'd0);
        send_word(16'h0F0F, 4'hF, 1'b0, 1'b0);
        chk("t5_sole", fb.o_fb_instr, 16'h0F0F);
        idle(1, 1'b1);
        chk("t5_drained", 16'(fb.o_fb_instr_vld), 16'd0);

        // 6: reset mid-word with one entry buffered
        send_word(16'h5555, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_vld", 16'(fb.o_fb_instr_vld), 16'd0);
        step(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
        chk("t6_nopush", 16'(fb.o_fb_instr_vld), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) != 0, 4'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 149) != 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
